// File: rtl/con_eval_unit_if.sv
// Handshake and result bundle between the control unit and the branch
// condition evaluator, plus a debug view of the evaluator FSM state.
interface con_eval_unit_if;
    logic        con_in;
    logic [3:0]  cond_sel;
    logic [31:0] bus_data;
    logic        con_ack;
    logic        count_clr;
    logic        con_out;
    logic        con_valid;
    logic        sel_err;
    logic [15:0] taken_cnt;
    logic [15:0] ntaken_cnt;
    logic [1:0]  fsm_state;

    // con_in is a one-cycle strobe honoured only in IDLE; a result is offered
    // with con_valid=1 and is held until con_ack=1 is seen at a rising edge.
    modport master (
        output con_in, cond_sel, bus_data, con_ack, count_clr,
        input  con_out, con_valid, sel_err, taken_cnt, ntaken_cnt, fsm_state
    );

    modport slave (
        input  con_in, cond_sel, bus_data, con_ack, count_clr,
        output con_out, con_valid, sel_err, taken_cnt, ntaken_cnt, fsm_state
    );
endinterface

// File: rtl/con_eval_unit.sv
// Branch condition evaluator: captures a bus value and one-hot condition,
// decides taken/not-taken, and keeps saturating taken/not-taken statistics.
module con_eval_unit (
    input  logic          clock,
    input  logic          clear,
    con_eval_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] cap_data;
    logic [3:0]  cap_sel;
    logic        con_out_q;
    logic        sel_err_q;
    logic [15:0] taken_q;
    logic [15:0] ntaken_q;
    logic        sel_ok;
    logic        decision;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.con_in)  state_d = EVAL;
            EVAL:    state_d = VALID;
            VALID:   if (bus.con_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decision uses only the captured copies so later bus activity cannot
    // disturb a pending result.
    always_comb begin
        sel_ok   = 1'b1;
        decision = 1'b0;
        case (cap_sel)
            4'b0001: decision = (cap_data == 32'd0);
            4'b0010: decision = (cap_data != 32'd0);
            4'b0100: decision = ~cap_data[31];
            4'b1000: decision = cap_data[31];
            default: sel_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cap_data <= 32'd0;
            cap_sel  <= 4'd0;
        end else if (state_q == IDLE && bus.con_in) begin
            cap_data <= bus.bus_data;
            cap_sel  <= bus.cond_sel;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            con_out_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else if (state_q == EVAL) begin
            con_out_q <= decision;
            if (!sel_ok) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    // Counter clear wins over a same-cycle increment; both counters stick at
    // all-ones rather than wrapping.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            taken_q  <= 16'd0;
            ntaken_q <= 16'd0;
        end else if (bus.count_clr) begin
            taken_q  <= 16'd0;
            ntaken_q <= 16'd0;
        end else if (state_q == EVAL && sel_ok) begin
            if (decision) begin
                if (taken_q != 16'hFFFF) begin
                    taken_q <= taken_q + 16'd1;
                end
            end else begin
                if (ntaken_q != 16'hFFFF) begin
                    ntaken_q <= ntaken_q + 16'd1;
                end
            end
        end
    end

    assign bus.con_out    = con_out_q;
    assign bus.con_valid  = (state_q == VALID);
    assign bus.sel_err    = sel_err_q;
    assign bus.taken_cnt  = taken_q;
    assign bus.ntaken_cnt = ntaken_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_con_eval_unit.sv
// Self-checking bench for con_eval_unit: reference decision model, expected
// result queue, counter model, handshake, saturation and async reset checks.
module tb_con_eval_unit;

    logic clock;
    logic clear;

    con_eval_unit_if cif ();

    con_eval_unit dut (
        .clock (clock),
        .clear (clear),
        .bus   (cif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [0:0]  exp_q[$];
    logic [15:0] m_taken;
    logic [15:0] m_ntaken;
    logic        m_sel_err;
    logic        m_out;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic ref_ok(input logic [3:0] s);
        return (s == 4'b0001) || (s == 4'b0010) || (s == 4'b0100) || (s == 4'b1000);
    endfunction

    function automatic logic ref_dec(input logic [3:0] s, input logic [31:0] d);
        if (!ref_ok(s)) return 1'b0;
        if (s[0]) return (d == 32'd0);
        if (s[1]) return (d != 32'd0);
        if (s[2]) return (d[31] == 1'b0);
        return (d[31] == 1'b1);
    endfunction

    task automatic model_reset();
        m_taken   = 16'd0;
        m_ntaken  = 16'd0;
        m_sel_err = 1'b0;
        m_out     = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_taken"},  cif.taken_cnt,  m_taken);
        check({tag, "_ntaken"}, cif.ntaken_cnt, m_ntaken);
        check({tag, "_selerr"}, cif.sel_err,    m_sel_err);
    endtask

    // One full transaction: strobe, scramble the bus during EVAL, wait for
    // the result, score it, then acknowledge.
    task automatic do_eval(input logic [3:0] sel, input logic [31:0] data, input bit clr_during);
        int   cycles;
        logic exp_out;
        @(negedge clock);
        cif.con_in   = 1'b1;
        cif.cond_sel = sel;
        cif.bus_data = data;
        exp_q.push_back(ref_dec(sel, data));
        @(negedge clock);
        cif.con_in    = 1'b0;
        cif.cond_sel  = 4'($urandom_range(0, 15));
        cif.bus_data  = $urandom;
        cif.count_clr = clr_during;
        check("valid_low_in_eval", cif.con_valid, 1'b0);
        @(negedge clock);
        cif.count_clr = 1'b0;
        cycles = 0;
        while (!cif.con_valid && cycles < 5) begin
            @(negedge clock);
            cycles++;
        end
        check("latency_extra_cycles", cycles, 0);
        if (cif.con_valid && exp_q.size() > 0) begin
            exp_out = exp_q.pop_front();
            check("con_out", cif.con_out, exp_out);
            m_out = exp_out;
        end
        if (clr_during) begin
            m_taken  = 16'd0;
            m_ntaken = 16'd0;
        end else if (ref_ok(sel)) begin
            if (ref_dec(sel, data)) begin
                if (m_taken != 16'hFFFF) m_taken++;
            end else begin
                if (m_ntaken != 16'hFFFF) m_ntaken++;
            end
        end
        if (!ref_ok(sel)) m_sel_err = 1'b1;
        check_outputs("post_eval");
        cif.con_ack = 1'b1;
        @(negedge clock);
        cif.con_ack = 1'b0;
        check("valid_after_ack", cif.con_valid, 1'b0);
        check("out_hold_idle", cif.con_out, m_out);
    endtask

    logic [31:0] data_tbl [6];
    logic        stable;

    initial begin
        data_tbl[0] = 32'h0000_0000;
        data_tbl[1] = 32'h0000_0001;
        data_tbl[2] = 32'h7FFF_FFFF;
        data_tbl[3] = 32'h8000_0000;
        data_tbl[4] = 32'hFFFF_FFFF;
        data_tbl[5] = 32'h1234_5678;

        cif.con_in    = 1'b0;
        cif.cond_sel  = 4'd0;
        cif.bus_data  = 32'd0;
        cif.con_ack   = 1'b0;
        cif.count_clr = 1'b0;
        model_reset();

        // Reset state
        clear = 1'b0;
        #12;
        check("rst_valid", cif.con_valid, 1'b0);
        check("rst_out",   cif.con_out,   1'b0);
        check("rst_state", cif.fsm_state, 2'd0);
        check_outputs("rst");
        @(negedge clock);
        clear = 1'b1;

        // Negative branch taken
        do_eval(4'b1000, 32'h8000_0001, 1'b0);
        check("neg_taken_cnt", cif.taken_cnt, 16'd1);

        // Zero boundary: zero is positive, and is not nonzero
        do_eval(4'b0100, 32'h0000_0000, 1'b0);
        do_eval(4'b0010, 32'h0000_0000, 1'b0);
        check("zero_ntaken_cnt", cif.ntaken_cnt, 16'd1);
        do_eval(4'b0001, 32'h0000_0000, 1'b0);
        do_eval(4'b0001, 32'h0000_0100, 1'b0);
        do_eval(4'b1000, 32'h7FFF_FFFF, 1'b0);
        do_eval(4'b0100, 32'hFFFF_FFFF, 1'b0);

        // Handshake: result held while con_ack stays low
        @(negedge clock);
        cif.con_in   = 1'b1;
        cif.cond_sel = 4'b0010;
        cif.bus_data = 32'h0000_00A5;
        @(negedge clock);
        cif.con_in = 1'b0;
        @(negedge clock);
        m_taken++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (cif.con_valid !== 1'b1 || cif.con_out !== 1'b1) stable = 1'b0;
            @(negedge clock);
        end
        check("hold_stable", stable, 1'b1);
        check("hold_valid", cif.con_valid, 1'b1);
        cif.con_ack  = 1'b1;
        cif.con_in   = 1'b1;
        cif.cond_sel = 4'b0001;
        cif.bus_data = 32'h0000_0000;
        @(negedge clock);
        cif.con_ack = 1'b0;
        cif.con_in  = 1'b0;
        check("ack_in_valid", cif.con_valid, 1'b0);
        check("ack_in_state", cif.fsm_state, 2'd0);
        @(negedge clock);
        check("no_capture_state", cif.fsm_state, 2'd0);
        check_outputs("no_capture");

        // Bad selects, then a good one keeps the sticky error
        do_eval(4'b0011, 32'h0000_0000, 1'b0);
        do_eval(4'b0000, 32'h8000_0000, 1'b0);
        do_eval(4'b1111, 32'h0000_0001, 1'b0);
        do_eval(4'b0010, 32'h0000_0001, 1'b0);
        check("selerr_sticky", cif.sel_err, 1'b1);

        // Randomised mix
        for (int i = 0; i < 24; i++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'(1 << $urandom_range(0, 3));
            do_eval(s, data_tbl[$urandom_range(0, 5)], 1'b0);
        end

        // Counter clear in IDLE leaves sel_err alone
        @(negedge clock);
        cif.count_clr = 1'b1;
        @(negedge clock);
        cif.count_clr = 1'b0;
        m_taken  = 16'd0;
        m_ntaken = 16'd0;
        check_outputs("idle_clr");

        // Saturation from a preloaded taken counter
        @(negedge clock);
        force dut.taken_q = 16'hFFFF;
        #1;
        release dut.taken_q;
        m_taken = 16'hFFFF;
        do_eval(4'b0100, 32'h0000_0001, 1'b0);
        check("sat_taken", cif.taken_cnt, 16'hFFFF);
        do_eval(4'b0100, 32'h0000_0002, 1'b1);
        check("clr_beats_inc", cif.taken_cnt, 16'd0);

        // Asynchronous reset while in EVAL
        do_eval(4'b1000, 32'h8000_0000, 1'b0);
        @(negedge clock);
        cif.con_in   = 1'b1;
        cif.cond_sel = 4'b0001;
        cif.bus_data = 32'h0000_0000;
        @(posedge clock);
        #2;
        cif.con_in = 1'b0;
        check("pre_rst_state_eval", cif.fsm_state, 2'd1);
        clear = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid", cif.con_valid, 1'b0);
        check("mid_rst_out",   cif.con_out,   1'b0);
        check("mid_rst_state", cif.fsm_state, 2'd0);
        check_outputs("mid_rst");
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("post_rst_state", cif.fsm_state, 2'd0);
        check_outputs("post_rst");
        do_eval(4'b0010, 32'h0000_0003, 1'b0);
        check("post_rst_taken", cif.taken_cnt, 16'd1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
